// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX deserializer and TX serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 27;  // 3.125 MHz / 115200 baud

endpackage

// File: rtl/uart_rx_deser_if.sv
// RX FIFO write port and receive status of the UART deserializer.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_deser_if;
  import uart_pkg::*;

  logic                 fr_full;
  logic                 fr_wr_en;
  logic [DATA_BITS-1:0] fr_data;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (input fr_full,
                  output fr_wr_en, fr_data, frame_err, overrun, rx_busy, parity_err);
  modport slave  (output fr_full,
                  input fr_wr_en, fr_data, frame_err, overrun, rx_busy, parity_err);
`else
  modport master (input fr_full,
                  output fr_wr_en, fr_data, frame_err, overrun, rx_busy);
  modport slave  (output fr_full,
                  input fr_wr_en, fr_data, frame_err, overrun, rx_busy);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, with selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled 8N1 frame recovery feeding the RX FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling stop bit, deciding write / overrun / framing error
// BREAK  | stop bit was low, waiting for the line to return high
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic             clk_3125_rx,
  input  logic             reset,
  input  logic             rx,
  uart_rx_deser_if.master  fr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic                 wr, wr_n;
  logic                 ferr, ferr_n;
  logic                 ovr, ovr_n;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 perr, perr_n;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk_3125_rx),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk_3125_rx) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      wr    <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      data  <= data_n;
      wr    <= wr_n;
      ferr  <= ferr_n;
      ovr   <= ovr_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
      perr    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        // The detection cycle is already the first clock of the start bit.
        if (!rx_s) begin
          state_n = START;
          cnt_n   = CW'(1);
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          par_bad_n = rx_s ^ (^shift);
          state_n   = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end else begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad) begin
`else
            begin
`endif
              if (fr.fr_full) begin
                ovr_n = 1'b1;
              end else begin
                wr_n   = 1'b1;
                data_n = shift;
              end
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  assign fr.fr_wr_en  = wr;
  assign fr.fr_data   = data;
  assign fr.frame_err = ferr;
  assign fr.overrun   = ovr;
  assign fr.rx_busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign fr.parity_err = perr;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: directed and random frames against an event-timing model.
// UART_RX_PARITY_EN switches the bench to 8E1 framing.
module tb_uart_rx_deser;
  import uart_pkg::*;

  localparam int CPB  = 27;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // From the edge that drives the start bit: 2 sync flops, half bit, then data/parity/stop bits.
  localparam int SAMPLE_OFS = 2 + HALF + (9 + PB) * CPB - 1;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] last_data = 8'h00;

  int         mon_wr_c[$], exp_wr_c[$];
  logic [7:0] mon_wr_d[$], exp_wr_d[$];
  int         mon_fe[$], exp_fe[$];
  int         mon_ov[$], exp_ov[$];
  int         mon_pe[$], exp_pe[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_deser_if fr ();

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
    .clk_3125_rx (clk),
    .reset       (reset),
    .rx          (rx),
    .fr          (fr)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (fr.fr_wr_en) begin
        mon_wr_c.push_back(cyc);
        mon_wr_d.push_back(fr.fr_data);
      end
      if (fr.frame_err) mon_fe.push_back(cyc);
      if (fr.overrun)   mon_ov.push_back(cyc);
`ifdef UART_RX_PARITY_EN
      if (fr.parity_err) mon_pe.push_back(cyc);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit full,
                            input bit par_ok, input int low_hold);
    int e;
    int s;
    e = cyc;
    s = e + SAMPLE_OFS;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      fr.fr_full = 1'($urandom_range(0, 1));
      send_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ^d : ~^d);
`endif
    fr.fr_full = full;
    send_bit(stop_ok);
    fr.fr_full = 1'b0;
    if (!stop_ok) begin
      idle(low_hold);
      rx = 1'b1;
    end
    if (!stop_ok) exp_fe.push_back(s + 1);
    if (!par_ok)  exp_pe.push_back(s + 1);
    if (stop_ok && par_ok) begin
      if (full) begin
        exp_ov.push_back(s + 1);
      end else begin
        exp_wr_c.push_back(s + 1);
        exp_wr_d.push_back(d);
        last_data = d;
      end
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nwr"}, mon_wr_c.size(), exp_wr_c.size());
    for (int i = 0; i < mon_wr_c.size() && i < exp_wr_c.size(); i++) begin
      chk({tag, "_wr_cyc"}, mon_wr_c[i], exp_wr_c[i]);
      chk({tag, "_wr_data"}, {24'h0, mon_wr_d[i]}, {24'h0, exp_wr_d[i]});
    end
    chk({tag, "_nfe"}, mon_fe.size(), exp_fe.size());
    for (int i = 0; i < mon_fe.size() && i < exp_fe.size(); i++)
      chk({tag, "_fe_cyc"}, mon_fe[i], exp_fe[i]);
    chk({tag, "_nov"}, mon_ov.size(), exp_ov.size());
    for (int i = 0; i < mon_ov.size() && i < exp_ov.size(); i++)
      chk({tag, "_ov_cyc"}, mon_ov[i], exp_ov[i]);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_npe"}, mon_pe.size(), exp_pe.size());
    for (int i = 0; i < mon_pe.size() && i < exp_pe.size(); i++)
      chk({tag, "_pe_cyc"}, mon_pe[i], exp_pe[i]);
`endif
    mon_wr_c.delete(); mon_wr_d.delete(); exp_wr_c.delete(); exp_wr_d.delete();
    mon_fe.delete(); exp_fe.delete(); mon_ov.delete(); exp_ov.delete();
    mon_pe.delete(); exp_pe.delete();
  endtask

  initial begin
    int e;
    logic [7:0] d;
    bit full, stop_ok, par_ok;

    reset = 1'b1;
    rx = 1'b1;
    fr.fr_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", fr.rx_busy, 0);
    chk("rst_wr", fr.fr_wr_en, 0);
    chk("rst_data", fr.fr_data, 0);
    chk("rst_ferr", fr.frame_err, 0);
    chk("rst_ovr", fr.overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(5);

    send_frame(8'hA5, 1, 0, 1, 0);
    idle(5);
    check_events("good");

    e = cyc;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    at_cyc(e + 8);
    chk("glitch_busy_hi", fr.rx_busy, 1);
    at_cyc(e + 2 + HALF);
    chk("glitch_busy_lo", fr.rx_busy, 0);
    @(posedge clk); #1;
    idle(40);
    check_events("glitch");

    send_frame(8'h3C, 0, 0, 1, 100);
    idle(10);
    send_frame(8'h55, 1, 0, 1, 0);
    idle(5);
    check_events("ferr");

    send_frame(8'h81, 1, 1, 1, 0);
    idle(5);
    check_events("ovr");
    @(negedge clk);
    chk("ovr_hold_data", fr.fr_data, {24'h0, last_data});
    @(posedge clk); #1;

    send_frame(8'h00, 1, 0, 1, 0);
    send_frame(8'hFF, 1, 0, 1, 0);
    idle(5);
    check_events("b2b");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    idle(10);
    reset = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rstmid_busy", fr.rx_busy, 0);
    chk("rstmid_data", fr.fr_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_data = 8'h00;
    idle(30);
    send_frame(8'h12, 1, 0, 1, 0);
`ifdef UART_RX_PARITY_EN
    idle(3);
    send_frame(8'h12, 1, 0, 0, 0);
`endif
    idle(5);
    check_events("rstmid");

    for (int k = 0; k < 8; k++) begin
      d       = 8'($urandom);
      full    = ($urandom_range(0, 3) == 0);
      stop_ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 4) != 0);
`else
      par_ok  = 1'b1;
`endif
      send_frame(d, stop_ok, full, par_ok, stop_ok ? 0 : int'($urandom_range(0, 60)));
      if (!stop_ok) idle(int'($urandom_range(1, 5)));
      else          idle(int'($urandom_range(0, 20)));
    end
    idle(5);
    check_events("rand");
    @(negedge clk);
    chk("rand_hold_data", fr.fr_data, {24'h0, last_data});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-side UART deserializer: oversamples the asynchronous serial line with a counter, recovers 8N1 frames (LSB first), and pushes each good byte into the RX FIFO through a one-cycle write strobe.
- Mirror of the TX path: where the TX FIFO feeds the serializer, this block feeds the RX FIFO.
- Runs on the 3.125 MHz RX clock; default baud 115200, 27 clocks per bit.

Parameters:
- CLKS_PER_BIT, 27, clock cycles per serial bit (must be >= 4).
- HALF_BIT, CLKS_PER_BIT/2 (13), sample offset from the falling edge of the start bit.

Ports:
- clk_3125_rx  in  1  RX clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- fr_full  in  1  RX FIFO full flag.
- fr_wr_en  out  1  one-cycle write strobe into the RX FIFO.
- fr_data  out  8  received byte; valid when fr_wr_en=1, held until the next frame completes.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte dropped because fr_full=1.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. All state is updated only on posedge clk_3125_rx.
- Input sync: 2-flop synchronizer on rx; both flops reset to 1. rx_s is the synchronized value.
- Reset values: state=IDLE, counter=0, bit index=0, shift register=0, fr_data=0, fr_wr_en=0, frame_err=0, overrun=0, rx_busy=0.
- Reset mid-frame aborts the frame immediately; no strobe or error is emitted.
- FSM, IDLE: counter held at 0. rx_s=0 -> START.
- FSM, START: counter counts up. At counter==HALF_BIT-1, sample rx_s:
  - 0 -> DATA, counter=0, bit index=0.
  - 1 -> IDLE (glitch reject, no outputs).
- FSM, DATA: at counter==CLKS_PER_BIT-1, shift rx_s into bit [index], LSB first, and clear the counter. After bit 7 -> STOP (or PARITY when the feature is enabled).
- FSM, STOP: at counter==CLKS_PER_BIT-1, sample rx_s:
  - 1 and fr_full=0 -> fr_data<=shift, fr_wr_en=1 for the next cycle only; -> IDLE.
  - 1 and fr_full=1 -> overrun=1 for one cycle; fr_data unchanged; no write; -> IDLE.
  - 0 -> frame_err=1 for one cycle; no write; -> BREAK.
- FSM, BREAK: wait until rx_s=1, then -> IDLE. A held-low line never produces a second frame.
- Latency: if t0 is the first cycle IDLE sees rx_s=0, the stop sample falls at t0+HALF_BIT+9*CLKS_PER_BIT-1 and fr_wr_en is high at t0+HALF_BIT+9*CLKS_PER_BIT (256 with defaults).
- Back-to-back frames: returning to IDLE at mid-stop gives half a bit of margin, so a start bit immediately following the stop bit is caught.
- fr_full is sampled only at the stop-sample cycle; changes on other cycles have no effect.
- Widths: counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits. Neither wraps: both are cleared on every state transition.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after bit 7. A PARITY state samples it at counter==CLKS_PER_BIT-1, then -> STOP. A mismatch raises parity_err (extra 1-bit output, one-cycle pulse coincident with the STOP decision) and suppresses the write; frame_err and overrun still apply as above.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=8, and the default CLKS_PER_BIT.
- The TX serializer shares this package.
- One sub-module, uart_sync2: the 2-flop synchronizer with a parameterised reset value. It is reusable for other async inputs.

Test Plan:
- Good frame: 0xA5, 8N1, 27 clocks/bit, fr_full=0 -> exactly one fr_wr_en pulse with fr_data=0xA5, 256 cycles after t0; frame_err=overrun=0.
- Glitch reject: rx low for 5 cycles, then high -> no fr_wr_en and no error; rx_busy returns to 0 by cycle 13.
- Framing error: 0x3C with stop=0 and the line held low for 100 cycles -> one frame_err pulse, no write. Then a valid 0x55 after the line goes high -> fr_data=0x55.
- Overrun: 0x81 with fr_full=1 -> one overrun pulse, no fr_wr_en, fr_data keeps its previous value.
- Back-to-back: 0x00 then 0xFF with zero idle gap -> two strobes exactly 270 cycles apart, data 0x00 then 0xFF.
- Reset mid-frame: reset asserted during bit 4 of 0xF0, then 0x12 sent -> no output for the aborted frame; one strobe with 0x12. With UART_RX_PARITY_EN, a bad parity bit on 0x12 -> parity_err pulse and no write.
